// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the single-cycle core. A word-wide synchronous RAM
// handles byte/half/word stores, and loads return extended data after one stall cycle.
module data_mem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        resp_valid,
  output logic        stall,
  output logic        fault,
  output logic        state_dbg_o
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word_q;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic        resp_valid_q;

  logic [AW-1:0] idx;
  logic          req, illegal_f3, store_bad, mis_h, mis_w;
  logic          fault_c, store_go, load_go;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   ext_word;
  logic          unused_addr_hi;

  assign idx            = addr[AW+1:2];
  assign unused_addr_hi = ^addr[31:AW+2];

  assign req        = MemRead | MemWr;
  assign illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  assign store_bad  = MemWr & funct3[2];
  assign mis_h      = (funct3[1:0] == 2'b01) & addr[0];
  assign mis_w      = (funct3 == 3'b010) & (addr[1:0] != 2'b00);

  // Faults are only reported for live requests while the FSM is ready to accept one.
  assign fault_c  = (state_q == IDLE) & ~rst & req & (illegal_f3 | store_bad | mis_h | mis_w);
  assign store_go = (state_q == IDLE) & ~rst & MemWr & ~fault_c;
  assign load_go  = (state_q == IDLE) & ~rst & MemRead & ~MemWr & ~fault_c;

  always_comb begin
    be       = 4'b1111;
    wd_lanes = wdata;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << addr[1:0];
        wd_lanes = {4{wdata[7:0]}};
      end
      2'b01: begin
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wd_lanes = wdata;
      end
    endcase
  end

  // Write lands at the request edge, so a load issued on the next cycle sees it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (store_go && be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
    end
    if (load_go) rd_word_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      lane_q       <= 2'b00;
      f3_q         <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          if (load_go) begin
            state_q      <= READ;
            resp_valid_q <= 1'b1;
            lane_q       <= addr[1:0];
            f3_q         <= funct3;
          end
        end
        READ: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    sel_byte = rd_word_q[8*lane_q +: 8];
    sel_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (f3_q)
      3'b000:  ext_word = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ext_word = {24'h0, sel_byte};
      3'b001:  ext_word = {{16{sel_half[15]}}, sel_half};
      3'b101:  ext_word = {16'h0, sel_half};
      default: ext_word = rd_word_q;
    endcase
  end

  // A reset arriving in READ drops the response before the core can write it back.
  assign resp_valid  = resp_valid_q & ~rst;
  assign rdata       = resp_valid ? ext_word : 32'h0;
  assign stall       = load_go;
  assign fault       = fault_c;
  assign state_dbg_o = (state_q == READ);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scenario-driven bench for data_mem_ctrl: expected load data is queued at issue
// and compared when the response cycle arrives.
module tb_data_mem_ctrl;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWr;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        resp_valid, stall, fault, state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [int];

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .AW(10)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWr(MemWr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .resp_valid(resp_valid),
    .stall(stall), .fault(fault), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (called just after a negedge) ----------------
  task automatic drive_idle();
    MemRead = 1'b0; MemWr = 1'b0; funct3 = 3'b010; addr = '0; wdata = '0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    MemRead = 1'b0; MemWr = 1'b1; funct3 = f3; addr = a; wdata = d;
    #1;
    tests_run++;
    if (stall !== 1'b0 || fault !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_%08h: stall=%b fault=%b resp_valid=%b, required 0/0/0", a, stall, fault, resp_valid);
    end
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp);
    logic [31:0] e;
    MemRead = 1'b1; MemWr = 1'b0; funct3 = f3; addr = a; wdata = '0;
    #1;
    tests_run++;
    if (stall !== 1'b1 || fault !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_issue_%08h: stall=%b fault=%b resp_valid=%b, required 1/0/0", a, stall, fault, resp_valid);
    end
    exp_q.push_back(exp);
    @(negedge clk);
    drive_idle();
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (resp_valid !== 1'b1 || stall !== 1'b0 || rdata !== e) begin
      tests_failed++;
      $display("FAIL load_resp_%08h f3=%0d: resp_valid=%b stall=%b rdata=%08h, required 1/0/%08h",
               a, f3, resp_valid, stall, rdata, e);
    end
    @(negedge clk);
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [31:0] a, input logic [2:0] f3);
    MemRead = rd; MemWr = wr; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
    #1;
    tests_run++;
    if (fault !== 1'b1 || stall !== 1'b0 || resp_valid !== 1'b0 || rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL fault_%08h f3=%0d: fault=%b stall=%b resp_valid=%b rdata=%08h, required 1/0/0/0",
               a, f3, fault, stall, resp_valid, rdata);
    end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (resp_valid !== 1'b0 || state_dbg !== 1'b0) begin
      tests_failed++;
      $display("FAIL fault_after_%08h: resp_valid=%b state=%b, required 0/0", a, resp_valid, state_dbg);
    end
    @(negedge clk);
  endtask

  // Bench-side reference for sized load extension.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] ln, input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ln +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (rdata !== 32'h0 || resp_valid !== 1'b0 || stall !== 1'b0 || fault !== 1'b0 || state_dbg !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: rdata=%08h rv=%b stall=%b fault=%b state=%b, required all 0",
               rdata, resp_valid, stall, fault, state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    do_store(32'h40, 32'hAAAA_AAAA, 3'b010);
    rst = 1'b1;
    MemWr = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'h1111_1111;
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    do_load(32'h40, 3'b010, 32'hAAAA_AAAA);
  endtask

  task automatic test_word();
    do_store(32'h10, 32'hDEAD_BEEF, 3'b010);
    drive_idle();
    @(negedge clk);
    do_load(32'h10, 3'b010, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte();
    do_store(32'h13, 32'h0000_0080, 3'b000);
    do_load(32'h13, 3'b000, 32'hFFFF_FF80);
    do_load(32'h13, 3'b100, 32'h0000_0080);
    do_load(32'h10, 3'b010, 32'h80AD_BEEF);
  endtask

  task automatic test_half();
    do_store(32'h20, 32'h1122_3344, 3'b010);
    do_store(32'h22, 32'h0000_8001, 3'b001);
    do_load(32'h22, 3'b001, 32'hFFFF_8001);
    do_load(32'h22, 3'b101, 32'h0000_8001);
    do_load(32'h20, 3'b010, 32'h8001_3344);
  endtask

  task automatic test_fault();
    do_fault(1'b1, 1'b0, 32'h11, 3'b010);
    do_fault(1'b0, 1'b1, 32'h21, 3'b001);
    do_fault(1'b1, 1'b0, 32'h20, 3'b011);
    do_fault(1'b0, 1'b1, 32'h20, 3'b100);
    do_fault(1'b0, 1'b1, 32'h12, 3'b010);
    do_load(32'h20, 3'b010, 32'h8001_3344);
    do_load(32'h10, 3'b010, 32'h80AD_BEEF);
  endtask

  task automatic test_back_to_back();
    do_store(32'h30, 32'h1234_5678, 3'b010);
    do_load(32'h30, 3'b010, 32'h1234_5678);
    do_store(32'h30 + 4*DEPTH, 32'hCAFE_F00D, 3'b010);
    do_load(32'h30, 3'b010, 32'hCAFE_F00D);
    MemRead = 1'b1; MemWr = 1'b1; funct3 = 3'b010; addr = 32'h50; wdata = 32'h0BAD_CAFE;
    #1;
    tests_run++;
    if (stall !== 1'b0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_wr_both: stall=%b fault=%b, required 0/0", stall, fault);
    end
    @(negedge clk);
    drive_idle();
    #1;
    tests_run++;
    if (resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_wr_both_resp: resp_valid=%b, required 0", resp_valid);
    end
    @(negedge clk);
    do_load(32'h50, 3'b010, 32'h0BAD_CAFE);
  endtask

  task automatic test_reset_in_read();
    MemRead = 1'b1; MemWr = 1'b0; funct3 = 3'b010; addr = 32'h30;
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (resp_valid !== 1'b0 || stall !== 1'b0 || state_dbg !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_read: resp_valid=%b stall=%b state=%b, required 0/0/0", resp_valid, stall, state_dbg);
    end
    @(negedge clk);
    do_load(32'h30, 3'b010, 32'hCAFE_F00D);
  endtask

  task automatic test_random();
    logic [31:0] a, d, w;
    logic [2:0]  f3;
    int          wi;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      model[i] = d;
      do_store(32'h200 + 4*i, d, 3'b010);
    end
    for (int n = 0; n < 60; n++) begin
      wi = $urandom_range(0, 7);
      case ($urandom_range(0, 2))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        default: f3 = 3'b010;
      endcase
      a = 32'h200 + 4*wi;
      if (f3 == 3'b000) a[1:0] = 2'($urandom_range(0, 3));
      if (f3 == 3'b001) a[1]   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        w = model[wi];
        case (f3)
          3'b000:  w[8*a[1:0] +: 8] = d[7:0];
          3'b001:  w[16*a[1] +: 16] = d[15:0];
          default: w = d;
        endcase
        model[wi] = w;
        do_store(a, d, f3);
      end else begin
        if ($urandom_range(0, 1) == 1 && f3 != 3'b010) f3 = f3 | 3'b100;
        do_load(a, f3, ref_load(model[wi], a[1:0], f3));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_back_to_back();
    test_reset_in_read();
    test_random();
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL leftover_expected: %0d entries, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end
endmodule
